// File: rtl/mult_ctrl_pkg.sv
// Shared definitions for the signed add-shift multiplier sequencer.
//   mult_state_t       : sequencer state encoding (3-bit)
//   MULT_WIDTH_DEFAULT : default operand width / iteration count
package mult_ctrl_pkg;

  localparam int unsigned MULT_WIDTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } mult_state_t;

endpackage

// File: rtl/iter_counter.sv
// Iteration counter for the multiplier sequencer.
// Ports:
//   Clk     : system clock, rising edge
//   Reset_n : asynchronous active-low reset (count -> 0)
//   clr     : synchronous clear (priority over inc)
//   inc     : advance; wraps to 0 after WIDTH-1
//   count   : current iteration index, 0..WIDTH-1
//   last    : count == WIDTH-1
module iter_counter #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CW    = $clog2(WIDTH)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] count_q, count_d;

  // Full-width compare: for non-power-of-2 WIDTH the counter wraps at
  // WIDTH-1 instead of rolling through the unused codes.
  assign last  = (count_q == CW'(WIDTH - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = last ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Control sequencer for the signed add-shift multiplier datapath.
// Each Run press clears A/X, then issues WIDTH add/shift pairs (subtract on
// the final, sign-bit iteration) and holds the result until Run is released.
// Ports:
//   Clk, Reset_n : clock (rising edge), asynchronous active-low reset
//   Run          : synchronised level, starts a multiply
//   ClearA_LoadB : synchronised level, in IDLE clears A/X and loads B
//   M            : current LSB of B
//   Clr_AX       : clear A and X registers
//   Ld_B         : load B from switches
//   Add_En       : load adder result into A and X
//   Sub          : adder computes A - S
//   Shift_En     : arithmetic right shift of X:A:B
//   Busy         : CLEAR through the last SHIFT
//   Done         : result held (HOLD)
module mult_sequencer
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_AX,
  output logic Ld_B,
  output logic Add_En,
  output logic Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int unsigned CW = $clog2(WIDTH);

  mult_state_t   state_q, state_d;
  logic          cnt_clr, cnt_inc, cnt_last;
  logic [CW-1:0] cnt;

  iter_counter #(
    .WIDTH (WIDTH)
  ) u_iter_counter (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .count   (cnt),
    .last    (cnt_last)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    Clr_AX   = 1'b0;
    Ld_B     = 1'b0;
    Add_En   = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Run takes priority over a simultaneous ClearA_LoadB request.
        if (Run) begin
          state_d = CLEAR;
        end else if (ClearA_LoadB) begin
          Clr_AX = 1'b1;
          Ld_B   = 1'b1;
        end
      end
      CLEAR: begin
        Clr_AX  = 1'b1;
        Busy    = 1'b1;
        cnt_clr = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        Busy    = 1'b1;
        Add_En  = M;
        Sub     = M & cnt_last;
        state_d = SHIFT;
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
        cnt_inc  = 1'b1;   // wraps to 0 on the last iteration
        state_d  = cnt_last ? HOLD : ADD;
      end
      HOLD: begin
        Done = 1'b1;
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  a_cnt_range : assert property (@(posedge Clk) disable iff (!Reset_n)
    cnt <= CW'(WIDTH - 1));
  a_add_shift_excl : assert property (@(posedge Clk) disable iff (!Reset_n)
    !(Add_En && Shift_En));
  a_sub_implies_add : assert property (@(posedge Clk) disable iff (!Reset_n)
    !Sub || Add_En);

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: a WIDTH=8 and a WIDTH=5 instance
// share the same stimulus and are compared each cycle against a phase-index
// reference model (phase -1 idle, 0 clear, odd add, even shift, 2W+1 hold).
module tb_mult_sequencer;

  logic Clk = 1'b0;
  logic Reset_n, Run, ClearA_LoadB, M;
  logic c8_clr, c8_ld, c8_add, c8_sub, c8_shf, c8_busy, c8_done;
  logic c5_clr, c5_ld, c5_add, c5_sub, c5_shf, c5_busy, c5_done;

  int vectors = 0;
  int miscompares = 0;
  int ph8 = -1;
  int ph5 = -1;
  int busy8, add8, shf8, sub8, done8, ld8;
  int busy5, add5, shf5, sub5;

  always #5 Clk = ~Clk;

  mult_sequencer #(.WIDTH(8)) u_dut8 (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_AX(c8_clr), .Ld_B(c8_ld), .Add_En(c8_add), .Sub(c8_sub),
    .Shift_En(c8_shf), .Busy(c8_busy), .Done(c8_done)
  );

  mult_sequencer #(.WIDTH(5)) u_dut5 (
    .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
    .Clr_AX(c5_clr), .Ld_B(c5_ld), .Add_En(c5_add), .Sub(c5_sub),
    .Shift_En(c5_shf), .Busy(c5_busy), .Done(c5_done)
  );

  // Output vector order: {Clr_AX, Ld_B, Add_En, Sub, Shift_En, Busy, Done}
  function automatic logic [6:0] model_out(int ph, int w, logic run, logic cl, logic m);
    logic [6:0] o;
    o = '0;
    if (ph < 0) begin
      if (!run && cl) o[6:5] = 2'b11;
    end else if (ph == 0) begin
      o[6] = 1'b1;
      o[1] = 1'b1;
    end else if (ph <= 2 * w) begin
      o[1] = 1'b1;
      if (ph % 2 == 1) begin
        o[4] = m;
        o[3] = m && (ph == 2 * w - 1);
      end else begin
        o[2] = 1'b1;
      end
    end else begin
      o[0] = 1'b1;
    end
    return o;
  endfunction

  function automatic int model_next(int ph, int w, logic run);
    if (ph < 0) return run ? 0 : -1;
    if (ph <= 2 * w) return ph + 1;
    return run ? ph : -1;
  endfunction

  task automatic chk_count(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_tally();
    busy8 = 0; add8 = 0; shf8 = 0; sub8 = 0; done8 = 0; ld8 = 0;
    busy5 = 0; add5 = 0; shf5 = 0; sub5 = 0;
  endtask

  task automatic step(input string tag, input logic rn, input logic run,
                      input logic cl, input logic m);
    logic [6:0] obs8, obs5, exp8, exp5;
    @(negedge Clk);
    Reset_n      = rn;
    Run          = run;
    ClearA_LoadB = cl;
    M            = m;
    if (!rn) begin
      ph8 = -1;
      ph5 = -1;
    end
    #1;
    obs8 = {c8_clr, c8_ld, c8_add, c8_sub, c8_shf, c8_busy, c8_done};
    obs5 = {c5_clr, c5_ld, c5_add, c5_sub, c5_shf, c5_busy, c5_done};
    exp8 = model_out(ph8, 8, run, cl, m);
    exp5 = model_out(ph5, 5, run, cl, m);
    vectors++;
    assert (obs8 === exp8) else begin
      miscompares++;
      $error("FAIL %s w8 ph=%0d observed=%b expected=%b", tag, ph8, obs8, exp8);
    end
    vectors++;
    assert (obs5 === exp5) else begin
      miscompares++;
      $error("FAIL %s w5 ph=%0d observed=%b expected=%b", tag, ph5, obs5, exp5);
    end
    busy8 += int'(c8_busy); add8 += int'(c8_add); shf8 += int'(c8_shf);
    sub8  += int'(c8_sub);  done8 += int'(c8_done); ld8 += int'(c8_ld);
    busy5 += int'(c5_busy); add5 += int'(c5_add); shf5 += int'(c5_shf);
    sub5  += int'(c5_sub);
    @(posedge Clk);
    if (rn) begin
      ph8 = model_next(ph8, 8, run);
      ph5 = model_next(ph5, 5, run);
    end
  endtask

  initial begin
    Reset_n = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b0; M = 1'b0;

    // Reset state, including IDLE ClearA_LoadB decode while reset is held
    step("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    step("reset_cl", 1'b0, 1'b0, 1'b1, 1'b0);
    step("release", 1'b1, 1'b0, 1'b0, 1'b0);

    // ClearA_LoadB held 3 cycles in IDLE
    clr_tally();
    for (int i = 0; i < 3; i++) step("idle_cl", 1'b1, 1'b0, 1'b1, 1'b0);
    step("idle_cl_off", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_count("idle_ld_cycles", ld8, 3);

    // All-ones multiplier; Run and ClearA_LoadB together at the press
    clr_tally();
    step("ones_press", 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 19; i++) step("ones", 1'b1, 1'b1, 1'(i % 2), 1'b1);
    step("ones_rel", 1'b1, 1'b0, 1'b0, 1'b1);
    step("ones_idle", 1'b1, 1'b0, 1'b0, 1'b1);
    chk_count("ones_busy8", busy8, 17);
    chk_count("ones_add8", add8, 8);
    chk_count("ones_shift8", shf8, 8);
    chk_count("ones_sub8", sub8, 1);
    chk_count("ones_ld8", ld8, 0);
    chk_count("ones_busy5", busy5, 11);
    chk_count("ones_add5", add5, 5);
    chk_count("ones_shift5", shf5, 5);
    chk_count("ones_sub5", sub5, 1);

    // All-zeros multiplier
    clr_tally();
    for (int i = 0; i < 20; i++) step("zeros", 1'b1, 1'b1, 1'b0, 1'b0);
    step("zeros_rel", 1'b1, 1'b0, 1'b0, 1'b0);
    step("zeros_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    chk_count("zeros_add8", add8, 0);
    chk_count("zeros_shift8", shf8, 8);
    chk_count("zeros_sub8", sub8, 0);
    chk_count("zeros_busy8", busy8, 17);

    // Run held 40 cycles: one busy window, then retrigger after a 1-cycle drop
    clr_tally();
    for (int i = 0; i < 40; i++) step("hold", 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk_count("hold_busy8", busy8, 17);
    chk_count("hold_done8", done8, 22);
    step("hold_drop", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("retrigger", 1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 20; i++) step("retrig_run", 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));

    // Reset during the 3rd SHIFT (phase 6 of the WIDTH=8 instance)
    step("mid_press", 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20 && ph8 != 6; i++) step("mid_run", 1'b1, 1'b0, 1'b0, 1'b1);
    step("mid_reset", 1'b0, 1'b0, 1'b0, 1'b1);
    clr_tally();
    for (int i = 0; i < 6; i++) step("after_reset", 1'b1, 1'b0, 1'b0, 1'b1);
    chk_count("after_reset_done", done8, 0);

    // Randomised traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step("random", 1'($urandom_range(0, 59) != 0), 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
